// File: rtl/ttt_game_ctrl_if.sv
// Keypad-to-sequencer bundle: raw key code in, board/game status out to the display blocks.
interface ttt_game_ctrl_if;
    logic [3:0]  key_data;
    logic        is_main;
    logic        is_turn_o;
    logic [17:0] board;
    logic [1:0]  result;
    logic [3:0]  move_count;
    logic        illegal;

    modport master (
        output key_data,
        input  is_main, is_turn_o, board, result, move_count, illegal
    );

    modport slave (
        input  key_data,
        output is_main, is_turn_o, board, result, move_count, illegal
    );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencer: keypad debouncer plus MAIN/PLAY/CHECK/RESULT game FSM.
// state    | meaning
// S_MAIN   | idle main screen, board cleared, waiting for start
// S_PLAY   | waiting for a cell key from the player to move
// S_CHECK  | one cycle: evaluate lines for the mover, draw on 9th move
// S_RESULT | game over, board/result held until start
module ttt_game_ctrl #(
    parameter int unsigned DEB_CNT   = 16,
    parameter logic [3:0]  KEY_START = 4'd10,
    parameter logic [3:0]  KEY_ABORT = 4'd11
) (
    input  logic            clk,
    input  logic            rst_n,
    ttt_game_ctrl_if.slave  bus
);

    localparam logic [15:0] CNT_MAX = 16'(DEB_CNT - 1);

    typedef enum logic [1:0] {S_MAIN, S_PLAY, S_CHECK, S_RESULT} st_t;

    logic [3:0]  key_q;
    logic [15:0] cnt;
    logic [3:0]  key_st;
    logic        key_evt;
    logic [3:0]  key_code;

    st_t         st, st_nx;
    logic [17:0] board_r, board_nx;
    logic        turn_r, turn_nx;
    logic [3:0]  mc_r, mc_nx;
    logic [1:0]  res_r, res_nx;
    logic        ill_r, ill_nx;

    logic [8:0]  x_cells, o_cells, mover_cells;
    logic [4:0]  x_bit, o_bit, set_bit;
    logic        cell_key;

    // Events fire only on release-to-press of the stable code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= 4'd0;
            cnt      <= 16'd0;
            key_st   <= 4'd0;
            key_evt  <= 1'b0;
            key_code <= 4'd0;
        end else begin
            key_q   <= bus.key_data;
            key_evt <= 1'b0;
            if (bus.key_data != key_q)
                cnt <= 16'd0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 16'd1;
            if (cnt == CNT_MAX) begin
                key_st <= key_q;
                if (key_st == 4'd0 && key_q != 4'd0) begin
                    key_evt  <= 1'b1;
                    key_code <= key_q;
                end
            end
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_cells
        assign x_cells[g] = board_r[16 - 2*g];
        assign o_cells[g] = board_r[17 - 2*g];
    end

    function automatic logic has_line(input logic [8:0] c);
        return (&c[2:0]) | (&c[5:3]) | (&c[8:6]) |
               (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]) |
               (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
    endfunction

    assign x_bit       = 5'd18 - {key_code, 1'b0};
    assign o_bit       = x_bit + 5'd1;
    assign set_bit     = turn_r ? o_bit : x_bit;
    assign cell_key    = (key_code >= 4'd1) && (key_code <= 4'd9);
    assign mover_cells = turn_r ? o_cells : x_cells;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_MAIN;
            board_r <= 18'd0;
            turn_r  <= 1'b0;
            mc_r    <= 4'd0;
            res_r   <= 2'b00;
            ill_r   <= 1'b0;
        end else begin
            st      <= st_nx;
            board_r <= board_nx;
            turn_r  <= turn_nx;
            mc_r    <= mc_nx;
            res_r   <= res_nx;
            ill_r   <= ill_nx;
        end
    end

    always_comb begin
        st_nx    = st;
        board_nx = board_r;
        turn_nx  = turn_r;
        mc_nx    = mc_r;
        res_nx   = res_r;
        ill_nx   = 1'b0;
        if (key_evt && key_code == KEY_ABORT) begin
            st_nx    = S_MAIN;
            board_nx = 18'd0;
            turn_nx  = 1'b0;
            mc_nx    = 4'd0;
            res_nx   = 2'b00;
        end else begin
            case (st)
                S_MAIN: begin
                    board_nx = 18'd0;
                    turn_nx  = 1'b0;
                    mc_nx    = 4'd0;
                    res_nx   = 2'b00;
                    if (key_evt && key_code == KEY_START)
                        st_nx = S_PLAY;
                end
                S_PLAY: begin
                    if (key_evt && cell_key) begin
                        if (board_r[x_bit] | board_r[o_bit]) begin
                            ill_nx = 1'b1;
                        end else begin
                            board_nx[set_bit] = 1'b1;
                            mc_nx             = mc_r + 4'd1;
                            st_nx             = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    // A completed line wins even on the ninth move.
                    if (has_line(mover_cells)) begin
                        res_nx = turn_r ? 2'b10 : 2'b01;
                        st_nx  = S_RESULT;
                    end else if (mc_r == 4'd9) begin
                        res_nx = 2'b11;
                        st_nx  = S_RESULT;
                    end else begin
                        turn_nx = ~turn_r;
                        st_nx   = S_PLAY;
                    end
                end
                S_RESULT: begin
                    if (key_evt && key_code == KEY_START) begin
                        st_nx    = S_MAIN;
                        board_nx = 18'd0;
                        turn_nx  = 1'b0;
                        mc_nx    = 4'd0;
                        res_nx   = 2'b00;
                    end
                end
                default: st_nx = S_MAIN;
            endcase
        end
    end

    assign bus.is_main    = (st == S_MAIN);
    assign bus.is_turn_o  = turn_r;
    assign bus.board      = board_r;
    assign bus.result     = res_r;
    assign bus.move_count = mc_r;
    assign bus.illegal    = ill_r;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: behavioural game model feeds a scoreboard checked after each key press.
module tb_ttt_game_ctrl;
    localparam int DEB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ttt_game_ctrl_if ifc ();

    ttt_game_ctrl #(.DEB_CNT(DEB), .KEY_START(4'd10), .KEY_ABORT(4'd11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct packed {
        logic [17:0] board;
        logic [1:0]  result;
        logic [3:0]  mc;
        logic        turn;
        logic        is_main;
        logic [1:0]  ill;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_fail = 0;

    logic [17:0] m_board;
    logic        m_turn;
    logic [3:0]  m_mc;
    logic [1:0]  m_res;
    int          m_st;
    int          m_ill;
    int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                         '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_board = '0; m_turn = 1'b0; m_mc = 4'd0; m_res = 2'b00; m_st = 0;
    endtask

    function automatic bit model_wins(input logic p);
        bit w = 0;
        for (int l = 0; l < 8; l++) begin
            bit all = 1;
            for (int j = 0; j < 3; j++)
                if (!m_board[18 - 2*lines[l][j] + int'(p)]) all = 0;
            if (all) w = 1;
        end
        return w;
    endfunction

    task automatic model_apply(input int k);
        m_ill = 0;
        if (k == 11) begin
            model_clear();
        end else if (m_st == 0) begin
            if (k == 10) m_st = 1;
        end else if (m_st == 1) begin
            if (k >= 1 && k <= 9) begin
                if (m_board[18 - 2*k] || m_board[19 - 2*k]) begin
                    m_ill = 1;
                end else begin
                    m_board[18 - 2*k + int'(m_turn)] = 1'b1;
                    m_mc = m_mc + 4'd1;
                    if (model_wins(m_turn)) begin
                        m_res = m_turn ? 2'b10 : 2'b01;
                        m_st = 2;
                    end else if (m_mc == 4'd9) begin
                        m_res = 2'b11;
                        m_st = 2;
                    end else begin
                        m_turn = ~m_turn;
                    end
                end
            end
        end else begin
            if (k == 10) model_clear();
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.board = m_board; e.result = m_res; e.mc = m_mc; e.turn = m_turn;
        e.is_main = (m_st == 0); e.ill = 2'(m_ill);
        return e;
    endfunction

    task automatic compare_sb(input int ill_seen);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        chk("board", 32'(ifc.board), 32'(e.board));
        chk("result", 32'(ifc.result), 32'(e.result));
        chk("move_count", 32'(ifc.move_count), 32'(e.mc));
        chk("is_turn_o", 32'(ifc.is_turn_o), 32'(e.turn));
        chk("is_main", 32'(ifc.is_main), 32'(e.is_main));
        chk("illegal_pulses", 32'(ill_seen), 32'(e.ill));
    endtask

    // Drive a code for n cycles, counting illegal pulses; starts and ends on a falling edge.
    task automatic drive(input logic [3:0] k, input int n, inout int ill_seen);
        ifc.key_data = k;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ifc.illegal) ill_seen++;
        end
    endtask

    task automatic press(input int k, input bit pin);
        logic [17:0] prev_board;
        int ill_seen = 0;
        prev_board = m_board;
        model_apply(k);
        sb.push_back(snap());
        ifc.key_data = 4'(k);
        for (int i = 1; i <= DEB + 4; i++) begin
            @(negedge clk);
            if (ifc.illegal) ill_seen++;
            if (pin && i == DEB + 1) chk("latency_before", 32'(ifc.board), 32'(prev_board));
            if (pin && i == DEB + 2) chk("latency_after", 32'(ifc.board), 32'(m_board));
        end
        drive(4'd0, DEB + 4, ill_seen);
        compare_sb(ill_seen);
    endtask

    task automatic play(input int moves[]);
        foreach (moves[i]) press(moves[i], 0);
    endtask

    initial begin
        int ill_seen;
        int nz;
        ifc.key_data = 4'd0;
        model_clear();
        m_ill = 0;
        repeat (3) @(negedge clk);
        chk("rst_is_main", 32'(ifc.is_main), 32'd1);
        chk("rst_board", 32'(ifc.board), 32'd0);
        chk("rst_result", 32'(ifc.result), 32'd0);
        chk("rst_move_count", 32'(ifc.move_count), 32'd0);
        chk("rst_turn", 32'(ifc.is_turn_o), 32'd0);
        chk("rst_illegal", 32'(ifc.illegal), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // X wins on the top row; latency pinned on the first move
        press(10, 0);
        press(1, 1);
        play('{4, 2, 5, 3});
        chk("xwin_result", 32'(ifc.result), 32'h1);
        chk("xwin_board", 32'(ifc.board), 32'h15A00);
        press(6, 0);
        chk("result_hold_board", 32'(ifc.board), 32'h15A00);
        press(10, 0);

        // occupied cell
        press(10, 0);
        press(1, 0);
        press(1, 0);
        chk("illegal_board", 32'(ifc.board), 32'h10000);
        chk("illegal_turn", 32'(ifc.is_turn_o), 32'd1);
        chk("illegal_mc", 32'(ifc.move_count), 32'd1);
        press(10, 0);
        press(11, 0);

        // draw
        press(10, 0);
        play('{1, 2, 3, 5, 4, 6, 8, 7, 9});
        chk("draw_result", 32'(ifc.result), 32'h3);
        chk("draw_mc", 32'(ifc.move_count), 32'd9);
        nz = 0;
        for (int c = 1; c <= 9; c++)
            if (ifc.board[18 - 2*c] || ifc.board[19 - 2*c]) nz++;
        chk("draw_cells_full", 32'(nz), 32'd9);
        press(10, 0);

        // win on the ninth move beats draw
        press(10, 0);
        play('{2, 1, 3, 6, 4, 8, 5, 9, 7});
        chk("win9_result", 32'(ifc.result), 32'h1);
        chk("win9_mc", 32'(ifc.move_count), 32'd9);
        press(10, 0);

        // short glitch, then 5 held and jumping straight to 7
        press(10, 0);
        ill_seen = 0;
        sb.push_back(snap());
        drive(4'd5, DEB - 2, ill_seen);
        drive(4'd0, DEB + 4, ill_seen);
        compare_sb(ill_seen);
        ill_seen = 0;
        model_apply(5);
        sb.push_back(snap());
        drive(4'd5, DEB + 2, ill_seen);
        drive(4'd7, DEB + 4, ill_seen);
        drive(4'd0, DEB + 4, ill_seen);
        compare_sb(ill_seen);
        chk("jump_board", 32'(ifc.board), 32'h00100);
        press(11, 0);

        // asynchronous reset mid-game
        press(10, 0);
        play('{1, 2, 3});
        rst_n = 1'b0;
        #1;
        chk("midrst_is_main", 32'(ifc.is_main), 32'd1);
        chk("midrst_board", 32'(ifc.board), 32'd0);
        chk("midrst_result", 32'(ifc.result), 32'd0);
        chk("midrst_mc", 32'(ifc.move_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        press(10, 0);
        press(5, 0);
        chk("after_rst_board", 32'(ifc.board), 32'h00100);

        // abort mid-game
        press(11, 0);
        press(10, 0);
        play('{1, 2, 3});
        press(11, 0);
        chk("abort_is_main", 32'(ifc.is_main), 32'd1);
        chk("abort_board", 32'(ifc.board), 32'd0);
        chk("abort_mc", 32'(ifc.move_count), 32'd0);
        press(10, 0);
        press(5, 0);
        chk("after_abort_board", 32'(ifc.board), 32'h00100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Game sequencer for the tic-tac-toe board datapath. It debounces raw keypad codes and runs the MAIN / PLAY / CHECK / RESULT state machine. It owns the 18-bit board register, the turn flag, the move counter and the result code. The 7-segment, dot-matrix and main-screen display blocks consume its outputs and hold no game state of their own.

## Interface
Parameters:
- DEB_CNT, 16: number of consecutive identical `key_data` samples that count as stable. Legal range is 2..65535.
- KEY_START, 4'd10: key code for start and new game.
- KEY_ABORT, 4'd11: key code that returns to MAIN from any state.

Ports:
- clk  in  1  system clock. There is one clock domain; every register is on `posedge clk`.
- rst_n  in  1  asynchronous, active-low reset.
- key_data  in  4  raw keypad code. 0 means no key, 1..9 are cells (row-major, 1 is top-left), 10 and 11 are commands, 12..15 are ignored.
- is_main  out  1  high while in MAIN.
- is_turn_o  out  1  0 means P1 (X) is to move, 1 means P2 (O) is to move.
- board  out  18  cell k (1..9) uses bit 18-2k for X and bit 19-2k for O.
- result  out  2  00 in progress, 01 X win, 10 O win, 11 draw.
- move_count  out  4  number of legal moves placed (0..9).
- illegal  out  1  one-cycle pulse when a cell key names an occupied cell.

## Operation
Debouncer:
- `key_q` samples `key_data` every cycle.
- Counter `cnt` clears when `key_data != key_q`. Otherwise it increments and saturates at DEB_CNT-1.
- When the counter reaches DEB_CNT-1, the stable code `key_st` loads `key_q`.
- `key_evt` is a registered one-cycle pulse. It fires only on a `key_st` transition from 0 to nonzero, and `key_code` captures the new value.
- A direct nonzero-to-nonzero change (for example 5 to 7 with no release) produces no event.
- Glitches shorter than DEB_CNT cycles produce no event.

State machine (state `st`):
- MAIN
  - Outputs: `is_main`=1, `board`=0, `result`=00, `is_turn_o`=0, `move_count`=0.
  - A `key_evt` with KEY_START moves to PLAY. All other codes are ignored.
- PLAY
  - A `key_evt` with a code k in 1..9 checks the cell. If both cell bits are 0, set bit 18-2k+`is_turn_o`, increment `move_count`, and go to CHECK.
  - If the cell is occupied, pulse `illegal` and stay in PLAY. Board and turn are unchanged.
  - KEY_START and codes 12..15 are ignored.
- CHECK (exactly one cycle)
  - Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board, for the mover only.
  - If the mover has a line: `result`=01 for X or 10 for O, then go to RESULT.
  - Else if `move_count`==9: `result`=11, then go to RESULT.
  - Else toggle `is_turn_o` and return to PLAY.
  - A win on the 9th move reports the win, not a draw.
  - A `key_evt` arriving in CHECK is dropped.
- RESULT
  - `board`, `result` and `is_turn_o` are held.
  - KEY_START goes to MAIN, which clears everything.
- Any state: KEY_ABORT goes to MAIN on the next edge. It takes priority over every other transition.

## Timing
- Reset values: state MAIN, `is_main`=1, `is_turn_o`=0, `board`=0, `result`=00, `move_count`=0, `illegal`=0, `key_q`=0, `cnt`=0, `key_st`=0, `key_evt`=0.
- Asserting reset mid-game clears state immediately. There is no pending-move carry-over.
- Press latency:
  - A key held stable from cycle t gives `key_evt` high in cycle t+DEB_CNT (±1 for the sampling register; the bench pins the exact value once).
  - `board` and `move_count` update at the edge ending the `key_evt` cycle (E+1).
  - `result` or the toggled `is_turn_o` update at E+2.
- `illegal` is high for exactly cycle E+1.
- Consecutive events are at least 2·DEB_CNT cycles apart, because a release is required. CHECK therefore never overlaps an accepted event.
- `move_count` never exceeds 9. No state accepts a 10th move.

## Test plan
- Reset, START, then moves 1,4,2,5,3 (X,O,X,O,X) → after the 5th move, `result`=01, `board`=18'h15A00, state RESULT. A further key 6 leaves `board` unchanged.
- START, then move 1, then key 1 again → `illegal` pulses for 1 cycle, `board`=18'h10000, `is_turn_o` stays 1, `move_count`=1.
- START, then moves 1,2,3,5,4,6,8,7,9 → after the 9th move, `result`=11, `move_count`=9, every cell pair is nonzero.
- START, then moves 2,1,3,6,4,8,5,9,7 → the 9th move completes the 3-5-7 line for X, so `result`=01, not 11.
- Glitch of code 5 lasting DEB_CNT-2 cycles between releases → no `key_evt` and the board is unchanged. A hold of 5 for DEB_CNT+2 cycles followed by a jump straight to 7 → exactly one event (code 5).
- Mid-game after 3 moves: assert `rst_n`=0 for 1 cycle, or send KEY_ABORT → `is_main`=1, `board`=0, `result`=00, `move_count`=0. Then START and move 5 → `board`=18'h00100.
